// File: rtl/pos_key_entry_if.sv
// Point-of-sale keypad bus.
// Carries the cursor position and the two active-low buttons into the entry
// engine. It also carries the engine's registered view of the transaction
// back out.
//   master : drives cursor_x/cursor_y/btn_sel/btn_clr, observes the results
//   slave  : the entry engine (pos_key_entry)
interface pos_key_entry_if;
    logic [3:0]  cursor_x;
    logic [3:0]  cursor_y;
    logic        btn_sel;
    logic        btn_clr;
    logic [1:0]  mode;
    logic [19:0] entry_val;
    logic [2:0]  entry_digits;
    logic [6:0]  qty_val;
    logic [26:0] total;
    logic [7:0]  item_cnt;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        err;
    logic        ovf;

    modport master (
        output cursor_x, cursor_y, btn_sel, btn_clr,
        input  mode, entry_val, entry_digits, qty_val, total, item_cnt,
               key_valid, key_code, err, ovf
    );

    modport slave (
        input  cursor_x, cursor_y, btn_sel, btn_clr,
        output mode, entry_val, entry_digits, qty_val, total, item_cnt,
               key_valid, key_code, err, ovf
    );
endinterface

// File: rtl/pos_key_entry.sv
// Point-of-sale key entry engine.
// Each button is edge-detected. The 4x4 key under the cursor is decoded, and
// price / quantity entry plus a saturating running total are maintained.
// Every result is registered one cycle after the press.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pos_key_entry_if.slave (cursor, buttons in; mode, entry, total,
//           item count, key pulse/code, err pulse, sticky ovf out)
module pos_key_entry #(
    parameter int unsigned TOTAL_MAX = 99_999_999
) (
    input logic            clk,
    input logic            rst_n,
    pos_key_entry_if.slave bus
);
    typedef enum logic [1:0] {PRICE = 2'd0, QTY = 2'd1, DONE = 2'd2} mode_t;

    localparam logic [3:0]  K_DZ  = 4'd10;
    localparam logic [3:0]  K_BS  = 4'd11;
    localparam logic [3:0]  K_MUL = 4'd12;
    localparam logic [3:0]  K_ADD = 4'd13;
    localparam logic [3:0]  K_CE  = 4'd14;
    localparam logic [3:0]  K_TOT = 4'd15;
    localparam logic [34:0] TOTAL_MAX_W = 35'(TOTAL_MAX);
    localparam logic [26:0] TOTAL_MAX_T = 27'(TOTAL_MAX);

    mode_t       mode_q;
    logic [19:0] entry_q;
    logic [2:0]  digits_q;
    logic [6:0]  qty_q;
    logic [26:0] total_q;
    logic [7:0]  item_cnt_q;
    logic        key_valid_q;
    logic [3:0]  key_code_q;
    logic        err_q;
    logic        ovf_q;
    logic        sel_d;
    logic        clr_d;

    function automatic logic [3:0] key_map(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] k;
        case ({y, x})
            4'h0: k = 4'd1;   4'h1: k = 4'd2;   4'h2: k = 4'd3;   4'h3: k = K_BS;
            4'h4: k = 4'd4;   4'h5: k = 4'd5;   4'h6: k = 4'd6;   4'h7: k = K_MUL;
            4'h8: k = 4'd7;   4'h9: k = 4'd8;   4'hA: k = 4'd9;   4'hB: k = K_ADD;
            4'hC: k = K_CE;   4'hD: k = 4'd0;   4'hE: k = K_DZ;   default: k = K_TOT;
        endcase
        return k;
    endfunction

    function automatic logic [26:0] sat_total(input logic [34:0] sum);
        return (sum > TOTAL_MAX_W) ? TOTAL_MAX_T : sum[26:0];
    endfunction

    function automatic logic [7:0] sat_items(input logic [8:0] sum);
        return sum[8] ? 8'd255 : sum[7:0];
    endfunction

    // Press = button low now, high last cycle; a held button fires once.
    logic        sel_press;
    logic        clr_press;
    logic        in_range;
    logic [3:0]  key;
    logic [34:0] add_amt;
    logic [34:0] sum_total;
    logic [8:0]  add_items;
    logic [8:0]  item_sum;

    assign sel_press = ~bus.btn_sel & sel_d;
    assign clr_press = ~bus.btn_clr & clr_d;
    assign in_range  = (bus.cursor_x < 4'd4) && (bus.cursor_y < 4'd4);
    assign key       = key_map(bus.cursor_x[1:0], bus.cursor_y[1:0]);

    // ADD contributes one line at entry price in PRICE, or price x qty in QTY.
    assign add_amt   = (mode_q == QTY) ? ({15'd0, entry_q} * {28'd0, qty_q})
                                       : {15'd0, entry_q};
    assign sum_total = {8'd0, total_q} + add_amt;
    assign add_items = (mode_q == QTY) ? {2'd0, qty_q} : 9'd1;
    assign item_sum  = {1'b0, item_cnt_q} + add_items;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= PRICE;
            entry_q     <= '0;
            digits_q    <= '0;
            qty_q       <= '0;
            total_q     <= '0;
            item_cnt_q  <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            sel_d       <= 1'b1;
            clr_d       <= 1'b1;
        end else begin
            sel_d       <= bus.btn_sel;
            clr_d       <= bus.btn_clr;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (clr_press) begin
                // Clear outranks a simultaneous select.
                mode_q     <= PRICE;
                entry_q    <= '0;
                digits_q   <= '0;
                qty_q      <= '0;
                total_q    <= '0;
                item_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end else if (sel_press) begin
                if (!in_range) begin
                    err_q <= 1'b1;
                end else begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= key;
                    case (mode_q)
                        PRICE: begin
                            if (key < 4'd10) begin
                                if (digits_q < 3'd6) begin
                                    entry_q  <= entry_q * 20'd10 + {16'd0, key};
                                    digits_q <= digits_q + 3'd1;
                                end else err_q <= 1'b1;
                            end else begin
                                case (key)
                                    K_DZ: if (digits_q <= 3'd4) begin
                                        entry_q  <= entry_q * 20'd100;
                                        digits_q <= digits_q + 3'd2;
                                    end else err_q <= 1'b1;
                                    K_BS: if (digits_q != 3'd0) begin
                                        entry_q  <= entry_q / 20'd10;
                                        digits_q <= digits_q - 3'd1;
                                    end else err_q <= 1'b1;
                                    K_MUL: if (digits_q != 3'd0) begin
                                        mode_q <= QTY;
                                        qty_q  <= '0;
                                    end else err_q <= 1'b1;
                                    K_ADD: if (digits_q != 3'd0) begin
                                        total_q    <= sat_total(sum_total);
                                        ovf_q      <= ovf_q | (sum_total > TOTAL_MAX_W);
                                        item_cnt_q <= sat_items(item_sum);
                                        entry_q    <= '0;
                                        digits_q   <= '0;
                                        qty_q      <= '0;
                                    end else err_q <= 1'b1;
                                    K_CE: begin
                                        entry_q  <= '0;
                                        digits_q <= '0;
                                        qty_q    <= '0;
                                    end
                                    K_TOT: if (digits_q == 3'd0 && item_cnt_q != 8'd0)
                                        mode_q <= DONE;
                                    else err_q <= 1'b1;
                                    default: err_q <= 1'b1;
                                endcase
                            end
                        end
                        QTY: begin
                            if (key < 4'd10) begin
                                if (qty_q < 7'd10) qty_q <= qty_q * 7'd10 + {3'd0, key};
                                else err_q <= 1'b1;
                            end else begin
                                case (key)
                                    // Empty quantity backs out to price entry, price kept.
                                    K_BS: if (qty_q != 7'd0) qty_q <= qty_q / 7'd10;
                                          else mode_q <= PRICE;
                                    K_ADD: if (qty_q != 7'd0) begin
                                        total_q    <= sat_total(sum_total);
                                        ovf_q      <= ovf_q | (sum_total > TOTAL_MAX_W);
                                        item_cnt_q <= sat_items(item_sum);
                                        entry_q    <= '0;
                                        digits_q   <= '0;
                                        qty_q      <= '0;
                                        mode_q     <= PRICE;
                                    end else err_q <= 1'b1;
                                    K_CE: begin
                                        entry_q  <= '0;
                                        digits_q <= '0;
                                        qty_q    <= '0;
                                        mode_q   <= PRICE;
                                    end
                                    default: err_q <= 1'b1;
                                endcase
                            end
                        end
                        DONE: begin
                            if (key == K_CE) begin
                                mode_q     <= PRICE;
                                entry_q    <= '0;
                                digits_q   <= '0;
                                qty_q      <= '0;
                                total_q    <= '0;
                                item_cnt_q <= '0;
                                ovf_q      <= 1'b0;
                            end else err_q <= 1'b1;
                        end
                        default: mode_q <= PRICE;
                    endcase
                end
            end
        end
    end

    assign bus.mode         = mode_q;
    assign bus.entry_val    = entry_q;
    assign bus.entry_digits = digits_q;
    assign bus.qty_val      = qty_q;
    assign bus.total        = total_q;
    assign bus.item_cnt     = item_cnt_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.key_code     = key_code_q;
    assign bus.err          = err_q;
    assign bus.ovf          = ovf_q;
endmodule

// File: tb/tb_pos_key_entry.sv
module tb_pos_key_entry;
    localparam longint TMAX = 99_999_999;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pos_key_entry_if bus();

    pos_key_entry #(.TOTAL_MAX(99_999_999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: transaction described as plain numbers.
    // Mode: 0 price, 1 quantity, 2 finished.
    int     km [4][4] = '{'{1, 2, 3, 11}, '{4, 5, 6, 12}, '{7, 8, 9, 13}, '{14, 0, 10, 15}};
    int     m_mode, m_digits, m_qty, m_items, m_kc;
    longint m_entry, m_total;
    bit     m_ovf, e_kv, e_err;

    task automatic model_reset();
        m_mode = 0; m_entry = 0; m_digits = 0; m_qty = 0; m_total = 0;
        m_items = 0; m_ovf = 0; m_kc = 0; e_kv = 0; e_err = 0;
    endtask

    task automatic model_clear();
        m_mode = 0; m_entry = 0; m_digits = 0; m_qty = 0; m_total = 0;
        m_items = 0; m_ovf = 0; e_kv = 0; e_err = 0;
    endtask

    task automatic model_drop_entry();
        m_entry = 0; m_digits = 0; m_qty = 0; m_mode = 0;
    endtask

    task automatic model_add();
        longint amount;
        int     cnt;
        amount  = (m_mode == 1) ? m_entry * m_qty : m_entry;
        cnt     = (m_mode == 1) ? m_qty : 1;
        m_total = m_total + amount;
        if (m_total > TMAX) begin
            m_total = TMAX;
            m_ovf   = 1;
        end
        m_items = (m_items + cnt > 255) ? 255 : m_items + cnt;
        model_drop_entry();
    endtask

    task automatic model_sel(int x, int y);
        int  k;
        bit  bad;
        e_kv = 0; e_err = 0; bad = 0;
        if (x > 3 || y > 3) begin
            e_err = 1;
            return;
        end
        k = km[y][x];
        e_kv = 1;
        m_kc = k;
        if (m_mode == 2) begin
            if (k == 14) model_clear(); else bad = 1;
            e_kv = 1;
        end else if (k <= 9) begin
            if (m_mode == 0) begin
                if (m_digits < 6) begin m_entry = m_entry * 10 + k; m_digits++; end
                else bad = 1;
            end else begin
                if (m_qty < 10) m_qty = m_qty * 10 + k; else bad = 1;
            end
        end else if (k == 14) begin
            model_drop_entry();
        end else if (m_mode == 0) begin
            if (k == 10) begin
                if (m_digits <= 4) begin m_entry = m_entry * 100; m_digits += 2; end
                else bad = 1;
            end else if (k == 11) begin
                if (m_digits > 0) begin m_entry = m_entry / 10; m_digits--; end
                else bad = 1;
            end else if (k == 12) begin
                if (m_digits > 0) begin m_mode = 1; m_qty = 0; end else bad = 1;
            end else if (k == 13) begin
                if (m_digits > 0) model_add(); else bad = 1;
            end else begin
                if (m_digits == 0 && m_items > 0) m_mode = 2; else bad = 1;
            end
        end else begin
            if (k == 11) begin
                if (m_qty > 0) m_qty = m_qty / 10; else m_mode = 0;
            end else if (k == 13) begin
                if (m_qty > 0) model_add(); else bad = 1;
            end else bad = 1;
        end
        e_err = bad;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".mode"},   bus.mode,         m_mode);
        chk({tag, ".entry"},  bus.entry_val,    m_entry);
        chk({tag, ".digits"}, bus.entry_digits, m_digits);
        chk({tag, ".qty"},    bus.qty_val,      m_qty);
        chk({tag, ".total"},  bus.total,        m_total);
        chk({tag, ".items"},  bus.item_cnt,     m_items);
        chk({tag, ".kv"},     bus.key_valid,    e_kv);
        chk({tag, ".kc"},     bus.key_code,     m_kc);
        chk({tag, ".err"},    bus.err,          e_err);
        chk({tag, ".ovf"},    bus.ovf,          m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(int x, int y, string tag);
        bus.cursor_x = x[3:0];
        bus.cursor_y = y[3:0];
        bus.btn_sel  = 1'b0;
        tick();
        model_sel(x, y);
        check_all(tag);
        bus.btn_sel = 1'b1;
        tick();
        e_kv = 0; e_err = 0;
        chk({tag, ".kv_end"},  bus.key_valid, 0);
        chk({tag, ".err_end"}, bus.err,       0);
    endtask

    task automatic press_clr(string tag, bit with_sel);
        bus.btn_clr = 1'b0;
        if (with_sel) bus.btn_sel = 1'b0;
        tick();
        model_clear();
        check_all(tag);
        bus.btn_clr = 1'b1;
        bus.btn_sel = 1'b1;
        tick();
    endtask

    initial begin
        int pulses;
        model_reset();
        bus.cursor_x = '0;
        bus.cursor_y = '0;
        bus.btn_sel  = 1'b1;
        bus.btn_clr  = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        rst_n = 1'b1;
        tick();

        // 1, 2 then ADD
        press(0, 0, "d1");
        press(1, 0, "d2");
        chk("r37.entry", bus.entry_val, 12);
        press(3, 2, "add12");
        chk("r37.total", bus.total, 12);
        chk("r37.items", bus.item_cnt, 1);

        // 250 x 3, ADD, TOT, then a rejected key while finished
        press_clr("clr38", 0);
        press(1, 0, "p2"); press(1, 1, "p5"); press(1, 3, "p0");
        press(3, 1, "mul");
        press(2, 0, "q3");
        press(3, 2, "add750");
        chk("r38.total", bus.total, 750);
        chk("r38.items", bus.item_cnt, 3);
        press(3, 3, "tot");
        chk("r38.mode", bus.mode, 2);
        bus.cursor_x = 4'd1; bus.cursor_y = 4'd1; bus.btn_sel = 1'b0;
        tick();
        model_sel(1, 1);
        check_all("done5");
        chk("r38.err", bus.err, 1);
        chk("r38.hold", bus.total, 750);
        bus.btn_sel = 1'b1;
        tick();

        // Seventh digit rejected, then backspace
        press(0, 3, "ce_done");
        press(0, 0, "s1"); press(1, 0, "s2"); press(2, 0, "s3");
        press(0, 1, "s4"); press(1, 1, "s5"); press(2, 1, "s6");
        bus.cursor_x = 4'd0; bus.cursor_y = 4'd2; bus.btn_sel = 1'b0;
        tick();
        model_sel(0, 2);
        chk("r39.entry", bus.entry_val, 123456);
        chk("r39.err", bus.err, 1);
        check_all("s7");
        bus.btn_sel = 1'b1;
        tick();
        press(3, 0, "bs");
        chk("r39.bs_entry", bus.entry_val, 12345);
        chk("r39.bs_digits", bus.entry_digits, 5);

        // Held select gives one pulse; select+clear together clears
        pulses = 0;
        bus.cursor_x = 4'd0; bus.cursor_y = 4'd0; bus.btn_sel = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) model_sel(0, 0);
            if (bus.key_valid === 1'b1) pulses++;
        end
        chk("r40.pulses", pulses, 1);
        bus.btn_sel = 1'b1;
        tick();
        e_kv = 0; e_err = 0;
        check_all("held");
        press_clr("selclr", 1);
        chk("r40.kv", bus.key_valid, 0);

        // Saturation: 999999 x 99 twice
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) press(2, 2, "n9");
            press(3, 1, "mul99");
            press(2, 2, "q9"); press(2, 2, "q9");
            press(3, 2, "add_big");
        end
        chk("r41.total", bus.total, TMAX);
        chk("r41.ovf", bus.ovf, 1);
        press_clr("clr41", 0);
        chk("r41.total0", bus.total, 0);
        chk("r41.ovf0", bus.ovf, 0);

        // Asynchronous reset in the middle of quantity entry
        press(1, 1, "a5"); press(3, 1, "amul"); press(2, 0, "aq3");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        tick();
        rst_n = 1'b1;
        tick();

        // Randomised key sequences against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 31);
            if (r == 0) press_clr("rnd_clr", 0);
            else if (r == 1) press_clr("rnd_selclr", 1);
            else press($urandom_range(0, 4), $urandom_range(0, 4), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
